// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate extend stage.
// Holds the format code enum and the RV32/RV64 base opcodes that the decoder recognises.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6,
        FMT_CSR  = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [2:0] F3_SYS_ILLEGAL = 3'b100;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder: classifies the instruction format,
// sign-extends the immediate to XLEN and flags encodings this stage does not support.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_fmt_e        fmt;
        logic            illegal;
    } dec_res_t;

    localparam bit IS_RV64 = (XLEN == 64);

    dec_res_t   res;
    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Each format's raw immediate is sign-extended by a signed size cast to XLEN.
    always_comb begin
        res.imm     = '0;
        res.fmt     = FMT_NONE;
        res.illegal = 1'b0;
        if (instr[1:0] != 2'b11) begin
            res.illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_OP: begin
                    res.fmt = FMT_R;
                end
                OPC_OP_32: begin
                    if (IS_RV64) res.fmt = FMT_R;
                    else         res.illegal = 1'b1;
                end
                OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM: begin
                    res.fmt = FMT_I;
                    res.imm = XLEN'($signed(instr[31:20]));
                end
                OPC_OP_IMM_32: begin
                    if (IS_RV64) begin
                        res.fmt = FMT_I;
                        res.imm = XLEN'($signed(instr[31:20]));
                    end else begin
                        res.illegal = 1'b1;
                    end
                end
                OPC_STORE: begin
                    res.fmt = FMT_S;
                    res.imm = XLEN'($signed({instr[31:25], instr[11:7]}));
                end
                OPC_BRANCH: begin
                    res.fmt = FMT_B;
                    res.imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                             instr[11:8], 1'b0}));
                end
                OPC_LUI, OPC_AUIPC: begin
                    res.fmt = FMT_U;
                    res.imm = XLEN'($signed({instr[31:12], 12'b0}));
                end
                OPC_JAL: begin
                    res.fmt = FMT_J;
                    res.imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                             instr[30:21], 1'b0}));
                end
                OPC_SYSTEM: begin
                    if (funct3 == F3_SYS_ILLEGAL) begin
                        res.illegal = 1'b1;
                    end else if (funct3[2]) begin
                        // CSR immediate forms carry an unsigned 5-bit zimm in the rs1 field.
                        res.fmt = FMT_CSR;
                        res.imm = XLEN'(instr[19:15]);
                    end else begin
                        res.fmt = FMT_I;
                        res.imm = XLEN'($signed(instr[31:20]));
                    end
                end
                default: begin
                    res.illegal = 1'b1;
                end
            endcase
        end
    end

    assign imm     = res.imm;
    assign fmt     = res.fmt;
    assign illegal = res.illegal;

endmodule

// File: rtl/imm_extend_stage.sv
// One-stage registered immediate extender between fetch and decode, with an
// optional second (skid) entry so in_ready can come straight from a flop.
module imm_extend_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output imm_fmt_e        out_fmt,
    output logic            out_illegal
);

    // Handshake: a transfer happens on any edge where valid && ready on that side;
    // valid never waits on ready, and a held output does not change until it transfers.

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        imm_fmt_e        fmt;
        logic            illegal;
    } entry_t;

    entry_t          in_ent;
    entry_t          out_d, out_q;
    entry_t          skid_d, skid_q;
    logic            out_valid_d, out_valid_q;
    logic            skid_valid_d, skid_valid_q;
    logic            in_fire;
    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign in_ent.instr   = in_instr;
    assign in_ent.pc      = in_pc;
    assign in_ent.imm     = dec_imm;
    assign in_ent.fmt     = dec_fmt;
    assign in_ent.illegal = dec_illegal;

    // With SKID the skid flag alone gates input; without it the stage can only
    // take an entry when the output register is empty or draining this cycle.
    assign in_ready = SKID ? !skid_valid_q : (!out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // The skid entry is older than anything on the input, so it drains first.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_d       = in_ent;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = in_ent;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_q.instr;
    assign out_pc      = out_q.pc;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage: an RV32 skid instance and an RV64
// single-register instance share the input stream and are checked field by field.
module tb_imm_extend_stage;
    import imm_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    logic [31:0] pc32;
    logic [63:0] pc64;

    logic        rdy32, vld32, ill32;
    logic [31:0] instr32, opc32, imm32;
    imm_fmt_e    fmt32;

    logic        rdy64, vld64, ill64;
    logic [31:0] instr64;
    logic [63:0] opc64, imm64;
    imm_fmt_e    fmt64;

    int vec_cnt;
    int err_cnt;

    imm_extend_stage #(.XLEN(32), .SKID(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_pc(pc32),
        .out_valid(vld32), .out_ready(out_ready), .out_instr(instr32), .out_pc(opc32),
        .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32)
    );

    imm_extend_stage #(.XLEN(64), .SKID(1'b0)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_pc(pc64),
        .out_valid(vld64), .out_ready(out_ready), .out_instr(instr64), .out_pc(opc64),
        .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b1;
        pc32      = '0;
        pc64      = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // driver: present one instruction for one edge, then look at the registered result
    task automatic drive_one(input logic [31:0] ins, input logic [63:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        pc32     = pc[31:0];
        pc64     = pc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        vecs.push_back('{32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF, FMT_I, 1'b0, 32'hFFFFFFFF, FMT_I, 1'b0});
        vecs.push_back('{32'h800000B7, 64'hFFFFFFFF_80000000, FMT_U, 1'b0, 32'h80000000, FMT_U, 1'b0});
        vecs.push_back('{32'h0000003B, 64'h0, FMT_R, 1'b0, 32'h0, FMT_NONE, 1'b1});
        vecs.push_back('{32'hFE000EE3, 64'hFFFFFFFF_FFFFFFFC, FMT_B, 1'b0, 32'hFFFFFFFC, FMT_B, 1'b0});
        vecs.push_back('{32'h300FD073, 64'h1F, FMT_CSR, 1'b0, 32'h1F, FMT_CSR, 1'b0});
        vecs.push_back('{32'h00000000, 64'h0, FMT_NONE, 1'b1, 32'h0, FMT_NONE, 1'b1});
        vecs.push_back('{32'h0000407F, 64'h0, FMT_NONE, 1'b1, 32'h0, FMT_NONE, 1'b1});
        vecs.push_back('{32'hFE112E23, 64'hFFFFFFFF_FFFFFFFC, FMT_S, 1'b0, 32'hFFFFFFFC, FMT_S, 1'b0});
        vecs.push_back('{32'h0080006F, 64'h8, FMT_J, 1'b0, 32'h8, FMT_J, 1'b0});
        vecs.push_back('{32'h00004073, 64'h0, FMT_NONE, 1'b1, 32'h0, FMT_NONE, 1'b1});
        vecs.push_back('{32'h00000073, 64'h0, FMT_I, 1'b0, 32'h0, FMT_I, 1'b0});
        vecs.push_back('{32'h002081B3, 64'h0, FMT_R, 1'b0, 32'h0, FMT_R, 1'b0});
        vecs.push_back('{32'hFFF0809B, 64'hFFFFFFFF_FFFFFFFF, FMT_I, 1'b0, 32'h0, FMT_NONE, 1'b1});
        vecs.push_back('{32'h00A00117, 64'h00A00000, FMT_U, 1'b0, 32'h00A00000, FMT_U, 1'b0});

        // reset state
        do_reset();
        check("rst_vld32", {63'd0, vld32}, 64'd0);
        check("rst_rdy32", {63'd0, rdy32}, 64'd1);
        check("rst_instr32", {32'd0, instr32}, 64'd0);
        check("rst_imm32", {32'd0, imm32}, 64'd0);
        check("rst_fmt32", {61'd0, fmt32}, {61'd0, FMT_NONE});
        check("rst_ill32", {63'd0, ill32}, 64'd0);
        check("rst_vld64", {63'd0, vld64}, 64'd0);
        check("rst_rdy64", {63'd0, rdy64}, 64'd1);
        check("rst_pc64", opc64, 64'd0);

        // decode vectors, one entry per handshake with out_ready high
        for (int i = 0; i < vecs.size(); i++) begin
            drive_one(vecs[i].ins, 64'h8000_0000_0000_1000 + 64'(i * 4));
            check("vld32", {63'd0, vld32}, 64'd1);
            check("instr32", {32'd0, instr32}, {32'd0, vecs[i].ins});
            check("pc32", {32'd0, opc32}, {32'd0, 32'h0000_1000 + 32'(i * 4)});
            check("imm32", {32'd0, imm32}, {32'd0, vecs[i].imm32});
            check("fmt32", {61'd0, fmt32}, {61'd0, vecs[i].fmt32});
            check("ill32", {63'd0, ill32}, {63'd0, vecs[i].ill32});
            check("vld64", {63'd0, vld64}, 64'd1);
            check("pc64", opc64, 64'h8000_0000_0000_1000 + 64'(i * 4));
            check("imm64", imm64, vecs[i].imm64);
            check("fmt64", {61'd0, fmt64}, {61'd0, vecs[i].fmt64});
            check("ill64", {63'd0, ill64}, {63'd0, vecs[i].ill64});
        end
        @(negedge clk);
        check("idle_vld32", {63'd0, vld32}, 64'd0);

        // back-pressure: A, B, C offered while downstream is stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        @(negedge clk);
        check("stall_A_vld", {63'd0, vld32}, 64'd1);
        check("stall_A_out", {32'd0, instr32}, 64'h00100093);
        check("stall_A_rdy", {63'd0, rdy32}, 64'd1);
        check("noskid_rdy_low", {63'd0, rdy64}, 64'd0);
        in_instr = 32'h00200093;
        @(negedge clk);
        check("stall_B_rdy", {63'd0, rdy32}, 64'd0);
        check("stall_B_out", {32'd0, instr32}, 64'h00100093);
        check("noskid_hold", {32'd0, instr64}, 64'h00100093);
        in_instr = 32'h00300093;
        @(negedge clk);
        check("stall_C_rdy", {63'd0, rdy32}, 64'd0);
        check("stall_C_out", {32'd0, instr32}, 64'h00100093);
        check("stall_C_imm", {32'd0, imm32}, 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_B_out", {32'd0, instr32}, 64'h00200093);
        check("drain_B_imm", {32'd0, imm32}, 64'd2);
        check("drain_B_rdy", {63'd0, rdy32}, 64'd1);
        @(negedge clk);
        check("drain_C_out", {32'd0, instr32}, 64'h00300093);
        check("drain_C_vld", {63'd0, vld32}, 64'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("drain_empty", {63'd0, vld32}, 64'd0);

        // flush with both entries full and an input offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00400093;
        @(negedge clk);
        in_instr = 32'h00500093;
        @(negedge clk);
        check("full_rdy", {63'd0, rdy32}, 64'd0);
        flush    = 1'b1;
        in_instr = 32'h00600093;
        @(negedge clk);
        check("flush_vld", {63'd0, vld32}, 64'd0);
        check("flush_rdy", {63'd0, rdy32}, 64'd1);
        check("flush_vld64", {63'd0, vld64}, 64'd0);
        // an input accepted during the flush cycle is discarded
        in_instr = 32'h00700093;
        @(negedge clk);
        check("flush_acc_vld", {63'd0, vld32}, 64'd0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("flush_no_ghost", {63'd0, vld32}, 64'd0);
        check("flush_no_ghost64", {63'd0, vld64}, 64'd0);

        // reset mid-stall clears both entries at once
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00800093;
        @(negedge clk);
        in_instr = 32'h00900093;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("arst_vld", {63'd0, vld32}, 64'd0);
        check("arst_rdy", {63'd0, rdy32}, 64'd1);
        check("arst_instr", {32'd0, instr32}, 64'd0);
        check("arst_vld64", {63'd0, vld64}, 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("arst_release", {63'd0, vld32}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
